fetch_queue: RTL

- Instruction-fetch stage that sits directly upstream of decode/control in the MIPS datapath.
- Owns the fetch PC and drives the instruction-memory address.
- Captures each fetched word together with its PC into a small FIFO and hands instructions to decode under a valid/ready handshake.
- Decode and branch/jump logic redirect it (taken branch, j, jal, jr); a halt input from syscall exit stops new fetches.

---
 rtl/fetch_queue.sv | 78 +++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Instruction-fetch stage: owns the fetch PC, captures {pc, instruction} pairs
// into a small FIFO and hands them to decode under a valid/ready handshake.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h00400000
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         redirect,
    input  logic [31:0]                  redirect_pc,
    input  logic                         halt,
    output logic [31:0]                  imem_addr,
    input  logic [31:0]                  imem_data,
    output logic                         dec_valid,
    input  logic                         dec_ready,
    output logic [31:0]                  dec_inst,
    output logic [31:0]                  dec_pc,
    output logic [31:0]                  dec_pc_plus4,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int            PW   = $clog2(DEPTH);
    localparam int            CW   = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   inst_q [DEPTH];
    logic [31:0]   pc_q   [DEPTH];
    logic          pop;
    logic          push;

    assign imem_addr = fetch_pc;
    assign dec_valid = (count != '0);
    assign pop       = dec_valid & dec_ready;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign push      = !redirect && !halt && ((count < FULL) || pop);

    // Head outputs read as zero while empty so stale storage never leaks out.
    assign dec_inst     = dec_valid ? inst_q[rd_ptr]          : '0;
    assign dec_pc       = dec_valid ? pc_q[rd_ptr]            : '0;
    assign dec_pc_plus4 = dec_valid ? (pc_q[rd_ptr] + 32'd4)  : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (redirect) begin
            // Redirect wins over push and pop: the head is discarded, not consumed.
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            rd_ptr   <= wr_ptr;
            count    <= '0;
        end else begin
            if (push) begin
                fetch_pc <= fetch_pc + 32'd4;
                wr_ptr   <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Queue storage carries data only; occupancy is tracked by count.
    always_ff @(posedge clock) begin
        if (push) begin
            inst_q[wr_ptr] <= imem_data;
            pc_q[wr_ptr]   <= fetch_pc;
        end
    end
endmodule
